int_issue_queue: RTL and testbench
==================================

# int_issue_queue

Reservation-station issue queue for one functional-unit class (ALU, MUL, DIV or AGU instance). Accepts instructions from the dispatch unit through a dispatch/full handshake, snoops the common data bus (CDB) to wake up operands waiting on producer tags, and issues ready instructions to its functional unit through a valid/ready handshake. Its `full` output is the queue-full indication consumed by the dispatch stall logic.

## Interface
- `DEPTH`, 4: number of entries (power of two, ≥2)
- `TAG_W`, 6: producer tag width
- `DATA_W`, 32: operand width
- `OP_W`, 4: opcode width
- `clk` in 1: clock, rising edge
- `rst_n` in 1: asynchronous, active-low reset
- `dispatch` in 1: dispatch request for this queue
- `disp_op` in OP_W: opcode
- `disp_rd_tag` in TAG_W: destination tag
- `disp_rs1_rdy`, `disp_rs2_rdy` in 1: operand already valid
- `disp_rs1_data`, `disp_rs2_data` in DATA_W: operand value when ready
- `disp_rs1_tag`, `disp_rs2_tag` in TAG_W: producer tag when not ready
- `full` out 1: no free entry; dispatch this cycle is not accepted
- `cdb_valid` in 1: CDB broadcast valid
- `cdb_tag` in TAG_W, `cdb_data` in DATA_W: broadcast tag and result
- `issue_valid` out 1: an entry is ready to issue
- `issue_ready` in 1: functional unit accepts
- `issue_op` out OP_W, `issue_rd_tag` out TAG_W, `issue_rs1`, `issue_rs2` out DATA_W: issued instruction

## Operation
- Entry fields: valid, op, rd_tag, and per operand {rdy, tag, data}.
- `full` = all entries valid (combinational from registered valid bits). No same-cycle credit for an issuing entry.
- Write: `dispatch & ~full` → lowest-index invalid entry loaded at clock edge. `dispatch & full` → request ignored, queue unchanged (dispatcher holds and retries).
- Dispatch-time CDB bypass: if an operand has rdy=0 and `cdb_valid` with `cdb_tag` equal to its tag in the same cycle, entry is written with rdy=1, data=`cdb_data`.
- Wakeup: each valid entry operand with rdy=0 and matching `cdb_tag` while `cdb_valid` captures `cdb_data`, sets rdy=1. One CDB broadcast may wake any number of operands across entries.
- Entry ready = valid & rs1.rdy & rs2.rdy. Selection: lowest-index ready entry (fixed priority).
- `issue_valid` = any entry ready; issue_* outputs show selected entry combinationally.
- `issue_valid & issue_ready` → selected entry's valid cleared at clock edge. Without `issue_ready`, selection may change next cycle if a lower-index entry becomes ready; outputs need not stay stable.
- Write and issue in the same cycle target different entries (write only to invalid entries, issue only from valid ones).

## Timing
- Reset (`rst_n` low, any time, asynchronous): all valid=0, all rdy=0; `full`=0, `issue_valid`=0, issue data outputs 0. Operation mid-flight is discarded.
- Dispatch at cycle N with both operands ready → `issue_valid` earliest at N+1.
- CDB match at cycle N → entry eligible at N+1.
- Issue accepted at N → entry free at N+1; `full` drops at N+1 if queue was full.
- Minimum dispatch-to-issue latency 1 cycle; throughput 1 dispatch and 1 issue per cycle.

## Structure
- Shared package `tomasulo_pkg`: entry struct typedef (`iq_entry_t`), operand struct (`iq_operand_t`), default TAG_W/DATA_W/OP_W constants; reusable by the other queue instances.
- One sub-module `iq_prio_enc` (DEPTH-bit find-first-set, outputs index and found flag), instantiated twice: free-entry select and ready-entry select.

## Test plan
- Reset, dispatch op=3, rd_tag=5, rs1=0x10, rs2=0x20 both ready → next cycle issue_valid=1, issue_rs1=0x10, issue_rs2=0x20; issue_ready=1 → entry freed.
- Fill DEPTH=4 entries with rs1 waiting on tag 7 → full=1; 5th dispatch ignored; CDB tag 7 data 0xAA → all four ready next cycle, issue in index order 0,1,2,3, full drops the cycle after first issue.
- Dispatch rs2 waiting on tag 9 with cdb_valid, cdb_tag=9, cdb_data=0x55 same cycle → entry issues next cycle with issue_rs2=0x55.
- Entry 2 ready, issue_ready=0 for 3 cycles, then entry 0 wakes → issue outputs switch to entry 0; entry 2 retained.
- Queue full, issue accepted and dispatch requested same cycle → dispatch rejected; repeated next cycle → accepted into freed index.
- Assert rst_n low with 3 valid entries mid-stream → full=0, issue_valid=0 immediately; prior entries never issue after release.

Source files
------------

// File: rtl/tomasulo_pkg.sv
// Shared types for the Tomasulo reservation-station issue queues (ALU, MUL, DIV, AGU).
// Entry and operand structs are sized by the default width constants below.
package tomasulo_pkg;

  localparam int DEF_TAG_W  = 6;
  localparam int DEF_DATA_W = 32;
  localparam int DEF_OP_W   = 4;

  typedef struct packed {
    logic                  rdy;
    logic [DEF_TAG_W-1:0]  tag;
    logic [DEF_DATA_W-1:0] data;
  } iq_operand_t;

  typedef struct packed {
    logic                 valid;
    logic [DEF_OP_W-1:0]  op;
    logic [DEF_TAG_W-1:0] rd_tag;
    iq_operand_t          rs1;
    iq_operand_t          rs2;
  } iq_entry_t;

  // A waiting operand whose producer tag is on the CDB captures the broadcast value.
  function automatic iq_operand_t iq_snoop(input iq_operand_t          opnd,
                                           input logic                 cdb_valid,
                                           input logic [DEF_TAG_W-1:0] cdb_tag,
                                           input logic [DEF_DATA_W-1:0] cdb_data);
    iq_operand_t res;
    res = opnd;
    if (!opnd.rdy && cdb_valid && (opnd.tag == cdb_tag)) begin
      res.rdy  = 1'b1;
      res.data = cdb_data;
    end
    return res;
  endfunction

endpackage

// File: rtl/iq_prio_enc.sv
// Find-first-set over a DEPTH-bit request vector; bit 0 has highest priority.
module iq_prio_enc #(
  parameter int DEPTH = 4
) (
  input  logic [DEPTH-1:0]         req,
  output logic [$clog2(DEPTH)-1:0] idx,
  output logic                     found
);

  localparam int IDX_W = $clog2(DEPTH);

  always_comb begin
    // NOTE: defaults assigned before the loop so no path leaves idx/found unassigned (no latch).
    idx   = '0;
    found = 1'b0;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      if (req[i]) begin
        idx   = IDX_W'(i);
        found = 1'b1;
      end
    end
  end

endmodule

// File: rtl/int_issue_queue.sv
// Reservation-station issue queue: dispatch into free entries, CDB wakeup,
// fixed-priority (lowest index) issue to one functional unit.
module int_issue_queue
  import tomasulo_pkg::*;
#(
  parameter int DEPTH  = 4,
  parameter int TAG_W  = DEF_TAG_W,
  parameter int DATA_W = DEF_DATA_W,
  parameter int OP_W   = DEF_OP_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              dispatch,
  input  logic [OP_W-1:0]   disp_op,
  input  logic [TAG_W-1:0]  disp_rd_tag,
  input  logic              disp_rs1_rdy,
  input  logic              disp_rs2_rdy,
  input  logic [DATA_W-1:0] disp_rs1_data,
  input  logic [DATA_W-1:0] disp_rs2_data,
  input  logic [TAG_W-1:0]  disp_rs1_tag,
  input  logic [TAG_W-1:0]  disp_rs2_tag,
  output logic              full,
  input  logic              cdb_valid,
  input  logic [TAG_W-1:0]  cdb_tag,
  input  logic [DATA_W-1:0] cdb_data,
  output logic              issue_valid,
  input  logic              issue_ready,
  output logic [OP_W-1:0]   issue_op,
  output logic [TAG_W-1:0]  issue_rd_tag,
  output logic [DATA_W-1:0] issue_rs1,
  output logic [DATA_W-1:0] issue_rs2
);

  localparam int IDX_W = $clog2(DEPTH);

  // The entry structs live in the shared package, so the widths must match it.
  if (TAG_W != DEF_TAG_W || DATA_W != DEF_DATA_W || OP_W != DEF_OP_W) begin : g_width_check
    $error("int_issue_queue: widths must match tomasulo_pkg defaults");
  end

  iq_entry_t        ent_q [DEPTH];
  iq_entry_t        disp_entry;
  iq_entry_t        sel_entry;
  logic [DEPTH-1:0] valid_vec;
  logic [DEPTH-1:0] ready_vec;
  logic [IDX_W-1:0] free_idx;
  logic [IDX_W-1:0] sel_idx;
  logic             free_found;
  logic             disp_accept;
  logic             issue_fire;

  always_comb begin
    valid_vec = '0;
    ready_vec = '0;
    for (int i = 0; i < DEPTH; i++) begin
      valid_vec[i] = ent_q[i].valid;
      ready_vec[i] = ent_q[i].valid & ent_q[i].rs1.rdy & ent_q[i].rs2.rdy;
    end
  end

  iq_prio_enc #(.DEPTH(DEPTH)) u_free_sel (
    .req   (~valid_vec),
    .idx   (free_idx),
    .found (free_found)
  );

  iq_prio_enc #(.DEPTH(DEPTH)) u_ready_sel (
    .req   (ready_vec),
    .idx   (sel_idx),
    .found (issue_valid)
  );

  // Full is based on registered valid bits only; an entry issuing this cycle frees up next cycle.
  assign full        = ~free_found;
  assign disp_accept = dispatch & ~full;
  assign issue_fire  = issue_valid & issue_ready;

  // Incoming entry, with the same-cycle CDB bypass applied to waiting operands.
  always_comb begin
    disp_entry          = '0;
    disp_entry.valid    = 1'b1;
    disp_entry.op       = disp_op;
    disp_entry.rd_tag   = disp_rd_tag;
    disp_entry.rs1.rdy  = disp_rs1_rdy;
    disp_entry.rs1.tag  = disp_rs1_tag;
    disp_entry.rs1.data = disp_rs1_rdy ? disp_rs1_data : '0;
    disp_entry.rs2.rdy  = disp_rs2_rdy;
    disp_entry.rs2.tag  = disp_rs2_tag;
    disp_entry.rs2.data = disp_rs2_rdy ? disp_rs2_data : '0;
    disp_entry.rs1      = iq_snoop(disp_entry.rs1, cdb_valid, cdb_tag, cdb_data);
    disp_entry.rs2      = iq_snoop(disp_entry.rs2, cdb_valid, cdb_tag, cdb_data);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: the whole entry array is reset (it is only DEPTH entries) so payloads never leak stale data.
      for (int i = 0; i < DEPTH; i++) begin
        ent_q[i] <= '0;
      end
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        // NOTE: non-blocking so every entry sees the same pre-edge state regardless of loop order.
        if (disp_accept && (free_idx == IDX_W'(i))) begin
          ent_q[i] <= disp_entry;
        end else if (ent_q[i].valid) begin
          if (issue_fire && (sel_idx == IDX_W'(i))) begin
            ent_q[i].valid <= 1'b0;
          end
          ent_q[i].rs1 <= iq_snoop(ent_q[i].rs1, cdb_valid, cdb_tag, cdb_data);
          ent_q[i].rs2 <= iq_snoop(ent_q[i].rs2, cdb_valid, cdb_tag, cdb_data);
        end
      end
    end
  end

  // Outputs are forced to zero when nothing is ready so the FU never sees stale payload.
  always_comb begin
    sel_entry = '0;
    if (issue_valid) begin
      sel_entry = ent_q[sel_idx];
    end
  end

  assign issue_op     = sel_entry.op;
  assign issue_rd_tag = sel_entry.rd_tag;
  assign issue_rs1    = sel_entry.rs1.data;
  assign issue_rs2    = sel_entry.rs2.data;

endmodule

// File: tb/tb_int_issue_queue.sv
// Directed self-checking bench for int_issue_queue (DEPTH=4).
module tb_int_issue_queue;

  logic        clk;
  logic        rst_n;
  logic        dispatch;
  logic [3:0]  disp_op;
  logic [5:0]  disp_rd_tag;
  logic        disp_rs1_rdy, disp_rs2_rdy;
  logic [31:0] disp_rs1_data, disp_rs2_data;
  logic [5:0]  disp_rs1_tag, disp_rs2_tag;
  logic        full;
  logic        cdb_valid;
  logic [5:0]  cdb_tag;
  logic [31:0] cdb_data;
  logic        issue_valid;
  logic        issue_ready;
  logic [3:0]  issue_op;
  logic [5:0]  issue_rd_tag;
  logic [31:0] issue_rs1, issue_rs2;

  int checks = 0;
  int errors = 0;

  int_issue_queue #(.DEPTH(4), .TAG_W(6), .DATA_W(32), .OP_W(4)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .dispatch      (dispatch),
    .disp_op       (disp_op),
    .disp_rd_tag   (disp_rd_tag),
    .disp_rs1_rdy  (disp_rs1_rdy),
    .disp_rs2_rdy  (disp_rs2_rdy),
    .disp_rs1_data (disp_rs1_data),
    .disp_rs2_data (disp_rs2_data),
    .disp_rs1_tag  (disp_rs1_tag),
    .disp_rs2_tag  (disp_rs2_tag),
    .full          (full),
    .cdb_valid     (cdb_valid),
    .cdb_tag       (cdb_tag),
    .cdb_data      (cdb_data),
    .issue_valid   (issue_valid),
    .issue_ready   (issue_ready),
    .issue_op      (issue_op),
    .issue_rd_tag  (issue_rd_tag),
    .issue_rs1     (issue_rs1),
    .issue_rs2     (issue_rs2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_disp(input logic en, input logic [3:0] op, input logic [5:0] rd,
                            input logic r1, input logic [31:0] d1, input logic [5:0] t1,
                            input logic r2, input logic [31:0] d2, input logic [5:0] t2);
    dispatch      = en;
    disp_op       = op;
    disp_rd_tag   = rd;
    disp_rs1_rdy  = r1;
    disp_rs1_data = d1;
    disp_rs1_tag  = t1;
    disp_rs2_rdy  = r2;
    disp_rs2_data = d2;
    disp_rs2_tag  = t2;
  endtask

  task automatic set_cdb(input logic v, input logic [5:0] t, input logic [31:0] d);
    cdb_valid = v;
    cdb_tag   = t;
    cdb_data  = d;
  endtask

  task automatic test_reset();
    #1;
    checks++; if (full !== 1'b0) begin errors++; $display("FAIL reset_full: got %0b expected 0", full); end
    checks++; if (issue_valid !== 1'b0) begin errors++; $display("FAIL reset_issue_valid: got %0b expected 0", issue_valid); end
    checks++; if (issue_op !== 4'd0 || issue_rd_tag !== 6'd0) begin errors++; $display("FAIL reset_issue_ctl: got op=%0h rd=%0h expected 0 0", issue_op, issue_rd_tag); end
    checks++; if (issue_rs1 !== 32'd0 || issue_rs2 !== 32'd0) begin errors++; $display("FAIL reset_issue_data: got %0h %0h expected 0 0", issue_rs1, issue_rs2); end
    @(negedge clk);
    rst_n = 1'b1;
    step();
  endtask

  task automatic test_basic();
    drive_disp(1, 4'd3, 6'd5, 1, 32'h10, 6'd0, 1, 32'h20, 6'd0);
    #1;
    checks++; if (issue_valid !== 1'b0) begin errors++; $display("FAIL basic_same_cycle: got %0b expected 0", issue_valid); end
    step();
    dispatch = 1'b0;
    #1;
    checks++; if (issue_valid !== 1'b1) begin errors++; $display("FAIL basic_valid: got %0b expected 1", issue_valid); end
    checks++; if (issue_op !== 4'd3 || issue_rd_tag !== 6'd5) begin errors++; $display("FAIL basic_ctl: got op=%0d rd=%0d expected 3 5", issue_op, issue_rd_tag); end
    checks++; if (issue_rs1 !== 32'h10 || issue_rs2 !== 32'h20) begin errors++; $display("FAIL basic_data: got %0h %0h expected 10 20", issue_rs1, issue_rs2); end
    issue_ready = 1'b1;
    step();
    issue_ready = 1'b0;
    #1;
    checks++; if (issue_valid !== 1'b0 || full !== 1'b0) begin errors++; $display("FAIL basic_freed: got valid=%0b full=%0b expected 0 0", issue_valid, full); end
  endtask

  task automatic test_fill_wakeup();
    for (int i = 0; i < 4; i++) begin
      drive_disp(1, 4'd1, 6'(10 + i), 0, 32'd0, 6'd7, 1, 32'(i), 6'd0);
      step();
    end
    drive_disp(1, 4'd2, 6'd20, 1, 32'd1, 6'd0, 1, 32'd2, 6'd0);
    #1;
    checks++; if (full !== 1'b1) begin errors++; $display("FAIL fill_full: got %0b expected 1", full); end
    checks++; if (issue_valid !== 1'b0) begin errors++; $display("FAIL fill_waiting: got %0b expected 0", issue_valid); end
    step();
    dispatch = 1'b0;
    set_cdb(1, 6'd7, 32'hAA);
    #1;
    checks++; if (full !== 1'b1 || issue_valid !== 1'b0) begin errors++; $display("FAIL fill_ignored: got full=%0b valid=%0b expected 1 0", full, issue_valid); end
    step();
    set_cdb(0, 6'd0, 32'd0);
    #1;
    checks++; if (issue_valid !== 1'b1 || issue_rd_tag !== 6'd10) begin errors++; $display("FAIL wake_first: got valid=%0b rd=%0d expected 1 10", issue_valid, issue_rd_tag); end
    checks++; if (issue_rs1 !== 32'hAA || issue_rs2 !== 32'd0) begin errors++; $display("FAIL wake_data: got %0h %0h expected aa 0", issue_rs1, issue_rs2); end
    issue_ready = 1'b1;
    step();
    checks++; if (full !== 1'b0) begin errors++; $display("FAIL drain_full_drop: got %0b expected 0", full); end
    for (int i = 1; i < 4; i++) begin
      checks++; if (issue_valid !== 1'b1 || issue_rd_tag !== 6'(10 + i) || issue_rs1 !== 32'hAA || issue_rs2 !== 32'(i))
        begin errors++; $display("FAIL drain_order_%0d: got valid=%0b rd=%0d rs1=%0h rs2=%0h expected 1 %0d aa %0h", i, issue_valid, issue_rd_tag, issue_rs1, issue_rs2, 10 + i, i); end
      step();
    end
    issue_ready = 1'b0;
    #1;
    checks++; if (issue_valid !== 1'b0) begin errors++; $display("FAIL drain_empty: got %0b expected 0", issue_valid); end
  endtask

  task automatic test_bypass();
    drive_disp(1, 4'd6, 6'd8, 1, 32'h1, 6'd0, 0, 32'd0, 6'd9);
    set_cdb(1, 6'd9, 32'h55);
    step();
    dispatch = 1'b0;
    set_cdb(0, 6'd0, 32'd0);
    #1;
    checks++; if (issue_valid !== 1'b1 || issue_rd_tag !== 6'd8) begin errors++; $display("FAIL bypass_valid: got valid=%0b rd=%0d expected 1 8", issue_valid, issue_rd_tag); end
    checks++; if (issue_rs1 !== 32'h1 || issue_rs2 !== 32'h55) begin errors++; $display("FAIL bypass_data: got %0h %0h expected 1 55", issue_rs1, issue_rs2); end
    issue_ready = 1'b1;
    step();
    issue_ready = 1'b0;
    #1;
    checks++; if (issue_valid !== 1'b0) begin errors++; $display("FAIL bypass_freed: got %0b expected 0", issue_valid); end
  endtask

  task automatic test_hold_switch();
    drive_disp(1, 4'd1, 6'd20, 0, 32'd0, 6'd3, 1, 32'd0, 6'd0);
    step();
    drive_disp(1, 4'd1, 6'd21, 0, 32'd0, 6'd4, 1, 32'd0, 6'd0);
    step();
    drive_disp(1, 4'd2, 6'd22, 1, 32'h22, 6'd0, 1, 32'h23, 6'd0);
    step();
    dispatch = 1'b0;
    for (int k = 0; k < 3; k++) begin
      #1;
      checks++; if (issue_valid !== 1'b1 || issue_rd_tag !== 6'd22) begin errors++; $display("FAIL hold_%0d: got valid=%0b rd=%0d expected 1 22", k, issue_valid, issue_rd_tag); end
      step();
    end
    set_cdb(1, 6'd3, 32'h33);
    #1;
    checks++; if (issue_rd_tag !== 6'd22) begin errors++; $display("FAIL hold_cdb_cycle: got rd=%0d expected 22", issue_rd_tag); end
    step();
    set_cdb(0, 6'd0, 32'd0);
    #1;
    checks++; if (issue_rd_tag !== 6'd20 || issue_rs1 !== 32'h33) begin errors++; $display("FAIL switch_to_0: got rd=%0d rs1=%0h expected 20 33", issue_rd_tag, issue_rs1); end
    issue_ready = 1'b1;
    step();
    checks++; if (issue_valid !== 1'b1 || issue_rd_tag !== 6'd22 || issue_rs2 !== 32'h23) begin errors++; $display("FAIL retained_2: got valid=%0b rd=%0d rs2=%0h expected 1 22 23", issue_valid, issue_rd_tag, issue_rs2); end
    step();
    issue_ready = 1'b0;
    #1;
    checks++; if (issue_valid !== 1'b0) begin errors++; $display("FAIL entry1_waits: got %0b expected 0", issue_valid); end
    set_cdb(1, 6'd4, 32'h44);
    step();
    set_cdb(0, 6'd0, 32'd0);
    #1;
    checks++; if (issue_rd_tag !== 6'd21 || issue_rs1 !== 32'h44) begin errors++; $display("FAIL wake_1: got rd=%0d rs1=%0h expected 21 44", issue_rd_tag, issue_rs1); end
    issue_ready = 1'b1;
    step();
    issue_ready = 1'b0;
    #1;
    checks++; if (issue_valid !== 1'b0) begin errors++; $display("FAIL hold_empty: got %0b expected 0", issue_valid); end
  endtask

  task automatic test_full_issue_dispatch();
    for (int i = 0; i < 4; i++) begin
      drive_disp(1, 4'd4, 6'(30 + i), 1, 32'(i), 6'd0, 1, 32'd0, 6'd0);
      step();
    end
    issue_ready = 1'b1;
    drive_disp(1, 4'd5, 6'd40, 1, 32'h40, 6'd0, 1, 32'h41, 6'd0);
    #1;
    checks++; if (full !== 1'b1 || issue_rd_tag !== 6'd30) begin errors++; $display("FAIL fid_full: got full=%0b rd=%0d expected 1 30", full, issue_rd_tag); end
    step();
    issue_ready = 1'b0;
    #1;
    checks++; if (full !== 1'b0 || issue_rd_tag !== 6'd31) begin errors++; $display("FAIL fid_rejected: got full=%0b rd=%0d expected 0 31", full, issue_rd_tag); end
    step();
    dispatch = 1'b0;
    #1;
    checks++; if (full !== 1'b1 || issue_rd_tag !== 6'd40 || issue_rs1 !== 32'h40) begin errors++; $display("FAIL fid_accepted: got full=%0b rd=%0d rs1=%0h expected 1 40 40", full, issue_rd_tag, issue_rs1); end
    issue_ready = 1'b1;
    for (int i = 1; i < 4; i++) begin
      step();
      checks++; if (issue_valid !== 1'b1 || issue_rd_tag !== 6'(30 + i)) begin errors++; $display("FAIL fid_drain_%0d: got valid=%0b rd=%0d expected 1 %0d", i, issue_valid, issue_rd_tag, 30 + i); end
    end
    step();
    issue_ready = 1'b0;
    #1;
    checks++; if (issue_valid !== 1'b0 || full !== 1'b0) begin errors++; $display("FAIL fid_empty: got valid=%0b full=%0b expected 0 0", issue_valid, full); end
  endtask

  task automatic test_reset_midstream();
    for (int i = 0; i < 3; i++) begin
      drive_disp(1, 4'd7, 6'(50 + i), 1, 32'(i + 1), 6'd0, 1, 32'd0, 6'd0);
      step();
    end
    dispatch = 1'b0;
    #1;
    checks++; if (issue_valid !== 1'b1 || issue_rd_tag !== 6'd50) begin errors++; $display("FAIL mid_pre: got valid=%0b rd=%0d expected 1 50", issue_valid, issue_rd_tag); end
    #1;
    rst_n = 1'b0;
    #1;
    checks++; if (full !== 1'b0 || issue_valid !== 1'b0) begin errors++; $display("FAIL mid_async: got full=%0b valid=%0b expected 0 0", full, issue_valid); end
    checks++; if (issue_rd_tag !== 6'd0 || issue_rs1 !== 32'd0) begin errors++; $display("FAIL mid_outputs: got rd=%0d rs1=%0h expected 0 0", issue_rd_tag, issue_rs1); end
    @(negedge clk);
    rst_n = 1'b1;
    issue_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      step();
      checks++; if (issue_valid !== 1'b0) begin errors++; $display("FAIL mid_no_issue_%0d: got %0b expected 0", k, issue_valid); end
    end
    issue_ready = 1'b0;
  endtask

  initial begin
    rst_n       = 1'b0;
    issue_ready = 1'b0;
    drive_disp(0, 4'd0, 6'd0, 0, 32'd0, 6'd0, 0, 32'd0, 6'd0);
    set_cdb(0, 6'd0, 32'd0);
    repeat (2) @(posedge clk);
    test_reset();
    test_basic();
    test_fill_wakeup();
    test_bypass();
    test_hold_switch();
    test_full_issue_dispatch();
    test_reset_midstream();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
